// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - circular {inst, pc} FIFO between instruction fetch and the decoder
//
// Optional feature macro: INSTQUEUE_BYPASS_EN (same-cycle empty-queue bypass to the decoder).
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global hold when low)
//   if_instqueue_en_in / _inst_in / _pc_in  : push from fetch
//   instqueue_if_full_out                   : queue holds 2**QUEUE_DEPTH_LOG entries
//   dispatcher_instqueue_rdy_in             : downstream can accept; enables pop
//   decoder_instqueue_rst_in, rob_instqueue_rst_in : flush requests
//   instqueue_decoder_en_out / _inst_out / _pc_out : head entry presented and popped
module inst_queue #(
    parameter int QUEUE_DEPTH_LOG = 4,
    parameter int INST_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  if_instqueue_en_in,
    input  logic [INST_WIDTH-1:0] if_instqueue_inst_in,
    input  logic [ADDR_WIDTH-1:0] if_instqueue_pc_in,
    output logic                  instqueue_if_full_out,
    input  logic                  dispatcher_instqueue_rdy_in,
    input  logic                  decoder_instqueue_rst_in,
    input  logic                  rob_instqueue_rst_in,
    output logic                  instqueue_decoder_en_out,
    output logic [INST_WIDTH-1:0] instqueue_decoder_inst_out,
    output logic [ADDR_WIDTH-1:0] instqueue_decoder_pc_out
);

    localparam int DEPTH = 1 << QUEUE_DEPTH_LOG;
    localparam logic [QUEUE_DEPTH_LOG:0] DEPTH_CNT = {1'b1, {QUEUE_DEPTH_LOG{1'b0}}};

    logic [INST_WIDTH-1:0]      inst_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]      pc_mem   [DEPTH];
    logic [QUEUE_DEPTH_LOG-1:0] head;
    logic [QUEUE_DEPTH_LOG-1:0] tail;
    logic [QUEUE_DEPTH_LOG:0]   count;

    logic flush;
    logic pop;
    logic push;
    logic bypass;

    assign flush = decoder_instqueue_rst_in | rob_instqueue_rst_in;
    assign pop   = rdy_in & dispatcher_instqueue_rdy_in & (count != '0);

`ifdef INSTQUEUE_BYPASS_EN
    // Empty queue and a consumer ready: hand the fetched entry straight through.
    assign bypass = rdy_in & if_instqueue_en_in & dispatcher_instqueue_rdy_in
                  & (count == '0) & ~flush;
`else
    assign bypass = 1'b0;
`endif

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push = rdy_in & if_instqueue_en_in & ((count != DEPTH_CNT) | pop) & ~bypass;

    assign instqueue_if_full_out    = (count == DEPTH_CNT);
    assign instqueue_decoder_en_out = pop | bypass;

    always_comb begin
        instqueue_decoder_inst_out = '0;
        instqueue_decoder_pc_out   = '0;
        if (bypass) begin
            instqueue_decoder_inst_out = if_instqueue_inst_in;
            instqueue_decoder_pc_out   = if_instqueue_pc_in;
        end else if (pop) begin
            instqueue_decoder_inst_out = inst_mem[head];
            instqueue_decoder_pc_out   = pc_mem[head];
        end
    end

    // Entry storage needs no reset: only slots between head and tail are ever read.
    always_ff @(posedge clk_in) begin
        if (push) begin
            inst_mem[tail] <= if_instqueue_inst_in;
            pc_mem[tail]   <= if_instqueue_pc_in;
        end
    end

    // Flush wins over rdy_in; the popped head is already on the outputs this cycle.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - directed self-checking bench for inst_queue
module tb_inst_queue;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        if_en;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        full;
    logic        disp_rdy;
    logic        dec_rst;
    logic        rob_rst;
    logic        en;
    logic [31:0] inst_out;
    logic [31:0] pc_out;

    int checks   = 0;
    int failures = 0;

    inst_queue dut (
        .clk_in                      (clk_in),
        .rst_in                      (rst_in),
        .rdy_in                      (rdy_in),
        .if_instqueue_en_in          (if_en),
        .if_instqueue_inst_in        (if_inst),
        .if_instqueue_pc_in          (if_pc),
        .instqueue_if_full_out       (full),
        .dispatcher_instqueue_rdy_in (disp_rdy),
        .decoder_instqueue_rst_in    (dec_rst),
        .rob_instqueue_rst_in        (rob_rst),
        .instqueue_decoder_en_out    (en),
        .instqueue_decoder_inst_out  (inst_out),
        .instqueue_decoder_pc_out    (pc_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_hold(input logic [31:0] pc);
        if_en   = 1'b1;
        if_pc   = pc;
        if_inst = pc ^ 32'hABCD0000;
        tick();
        if_en   = 1'b0;
    endtask

    logic [31:0] exp_q[$];
    int          pushed;
    int          budget;
    int          sz;
    logic        do_push;
    logic        exp_pop;
    logic        byp;

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; if_en = 1'b0; if_inst = '0; if_pc = '0;
        disp_rdy = 1'b0; dec_rst = 1'b0; rob_rst = 1'b0;
        disp_rdy = 1'b1;
        #1;
        check("rst_en", en, 1'b0);
        check("rst_full", full, 1'b0);
        check("rst_inst", inst_out, 32'h0);
        check("rst_pc", pc_out, 32'h0);
        disp_rdy = 1'b0;
        tick(); tick();
        rst_in = 1'b1;
        tick();

        // Fill 16 entries with the dispatcher stalled.
        for (int i = 0; i < 16; i++) begin
            check("fill_not_full", full, 1'b0);
            push_hold(32'(i * 4));
        end
        check("full_after_16", full, 1'b1);
        check("full_no_en", en, 1'b0);
        push_hold(32'h40);                 // dropped
        check("full_after_drop", full, 1'b1);

        // Full queue: push 0x100 together with a pop.
        if_en = 1'b1; if_pc = 32'h100; if_inst = 32'h100 ^ 32'hABCD0000; disp_rdy = 1'b1;
        #1;
        check("fp_en", en, 1'b1);
        check("fp_pc", pc_out, 32'h0);
        tick();
        if_en = 1'b0; disp_rdy = 1'b0;
        #1;
        check("fp_still_full", full, 1'b1);
        disp_rdy = 1'b1;
        for (int i = 1; i < 16; i++) begin
            #1;
            check("drain_en", en, 1'b1);
            check("drain_pc", pc_out, 32'(i * 4));
            check("drain_inst", inst_out, 32'(i * 4) ^ 32'hABCD0000);
            tick();
        end
        check("last_pc", pc_out, 32'h100);
        check("last_en", en, 1'b1);
        tick();
        check("drained_en", en, 1'b0);
        check("drained_pc", pc_out, 32'h0);

        // Random interleave of 40 pushes against a scoreboard.
        pushed = 0; budget = 0;
        while ((pushed < 40 || exp_q.size() != 0) && budget < 600) begin
            budget++;
            do_push  = (pushed < 40) && ($urandom_range(0, 2) != 0);
            disp_rdy = ($urandom_range(0, 2) == 0);
            if_en    = do_push;
            if_pc    = 32'h1000 + 32'(pushed * 4);
            if_inst  = if_pc ^ 32'hABCD0000;
            #1;
            sz      = exp_q.size();
            exp_pop = disp_rdy && (sz != 0);
            byp     = 1'b0;
`ifdef INSTQUEUE_BYPASS_EN
            byp = disp_rdy && (sz == 0) && do_push;
`endif
            check("rnd_en", en, exp_pop | byp);
            check("rnd_full", full, sz == 16);
            if (exp_pop) begin
                check("rnd_pc", pc_out, exp_q[0]);
                check("rnd_inst", inst_out, exp_q[0] ^ 32'hABCD0000);
                void'(exp_q.pop_front());
            end else if (byp) begin
                check("rnd_byp_pc", pc_out, if_pc);
            end
            if (do_push) begin
                if (byp) pushed++;
                else if (sz < 16 || exp_pop) begin
                    exp_q.push_back(if_pc);
                    pushed++;
                end
            end
            tick();
        end
        check("rnd_budget", 32'(budget < 600), 32'h1);
        if_en = 1'b0; disp_rdy = 1'b0;

        // Decoder flush with a concurrent push.
        for (int i = 0; i < 5; i++) push_hold(32'h300 + 32'(i * 4));
        disp_rdy = 1'b1; dec_rst = 1'b1;
        if_en = 1'b1; if_pc = 32'h400; if_inst = 32'h400;
        #1;
        check("flush_pop_en", en, 1'b1);
        check("flush_pop_pc", pc_out, 32'h300);
        tick();
        dec_rst = 1'b0; if_en = 1'b0;
        #1;
        check("flush_after_en", en, 1'b0);
        check("flush_after_pc", pc_out, 32'h0);
        check("flush_after_full", full, 1'b0);
        tick();
        check("flush_gone_en", en, 1'b0);

        // rdy_in low holds everything.
        disp_rdy = 1'b0;
        for (int i = 0; i < 3; i++) push_hold(32'h500 + 32'(i * 4));
        rdy_in = 1'b0; disp_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_en = 1'b1; if_pc = 32'h600; if_inst = 32'h600;
            #1;
            check("hold_en", en, 1'b0);
            tick();
        end
        if_en = 1'b0; rdy_in = 1'b1;
        #1;
        check("hold_head_pc", pc_out, 32'h500);
        tick();
        check("hold_next_pc", pc_out, 32'h504);
        rdy_in = 1'b0; rob_rst = 1'b1;
        tick();
        rob_rst = 1'b0; rdy_in = 1'b1;
        #1;
        check("rob_flush_en", en, 1'b0);
        tick();
        check("rob_flush_en2", en, 1'b0);

        // Empty queue push straight to a ready dispatcher.
        if_en = 1'b1; if_pc = 32'h200; if_inst = 32'h00000013;
        #1;
`ifdef INSTQUEUE_BYPASS_EN
        check("byp_same_en", en, 1'b1);
        check("byp_same_inst", inst_out, 32'h00000013);
        check("byp_same_pc", pc_out, 32'h200);
        tick();
        if_en = 1'b0;
        #1;
        check("byp_next_en", en, 1'b0);
`else
        check("nobyp_same_en", en, 1'b0);
        tick();
        if_en = 1'b0;
        #1;
        check("nobyp_next_en", en, 1'b1);
        check("nobyp_next_inst", inst_out, 32'h00000013);
        check("nobyp_next_pc", pc_out, 32'h200);
`endif
        tick();
        check("byp_empty_en", en, 1'b0);

        // Asynchronous reset mid-operation.
        disp_rdy = 1'b0;
        push_hold(32'h700);
        push_hold(32'h704);
        disp_rdy = 1'b1;
        #1;
        check("pre_rst_pc", pc_out, 32'h700);
        #2;
        rst_in = 1'b0;
        #1;
        check("async_rst_en", en, 1'b0);
        check("async_rst_pc", pc_out, 32'h0);
        tick();
        rst_in = 1'b1;
        tick();
        check("post_rst_en", en, 1'b0);
        check("post_rst_full", full, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
